// File: rtl/tim1_pkg.sv
// Shared definitions for the TIM1 channel-1 dead-time generator:
// FSM state encoding, default dead-time width and the settle-state helper.
package tim1_pkg;

  localparam int DT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMP_ON = 3'd1,
    ST_DEAD_R  = 3'd2,
    ST_MAIN_ON = 3'd3,
    ST_DEAD_F  = 3'd4
  } dtg_state_e;

  // Steady state that matches a reference level, used whenever no dead time applies.
  function automatic dtg_state_e settle_state(input logic ref_lvl);
    return ref_lvl ? ST_MAIN_ON : ST_COMP_ON;
  endfunction

endpackage

// File: rtl/tim1_dt_cnt.sv
// Loadable down-counter for the dead-time interval; zero_o flags an expired count.
module tim1_dt_cnt
  import tim1_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [DT_W-1:0] load_val_i,
  input  logic            dec_i,
  output logic            zero_o
);

  logic [DT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tim1_dtg.sv
// Channel-1 complementary output stage with dead-time insertion, polarity,
// single-output modes and main-output-enable idle forcing. All outputs registered.
module tim1_dtg
  import tim1_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_oc1ref,
  input  logic            i_cc1E,
  input  logic            i_cc1P,
  input  logic            i_cc1NE,
  input  logic            i_cc1NP,
  input  logic            i_moe,
  input  logic            i_ois1,
  input  logic            i_ois1n,
  input  logic [DT_W-1:0] i_dtg,
  output logic            o_oc1,
  output logic            o_oc1n,
  output logic            o_dt_busy,
  output logic [2:0]      o_dbg_state
);

  dtg_state_e      state_q, state_d;
  logic            cc1e_q, cc1ne_q;
  logic            oc1_q, oc1_d, oc1n_q, oc1n_d, busy_q, busy_d;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic            comp_mode, en_chg, dt_zero;
  logic [DT_W-1:0] dtg_m1;

  assign comp_mode = i_cc1E & i_cc1NE;
  assign en_chg    = (i_cc1E != cc1e_q) | (i_cc1NE != cc1ne_q);
  assign dt_zero   = (i_dtg == '0);
  // Loading dtg-1 makes the settled state appear exactly dtg edges after the ref edge.
  assign dtg_m1    = i_dtg - 1'b1;

  tim1_dt_cnt #(.DT_W(DT_W)) u_dt_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (dtg_m1),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (!i_moe) begin
      state_d = ST_IDLE;
    end else if ((state_q == ST_IDLE) || !comp_mode || en_chg) begin
      state_d = settle_state(i_oc1ref);
    end else begin
      case (state_q)
        ST_COMP_ON: if (i_oc1ref) begin
          state_d  = dt_zero ? ST_MAIN_ON : ST_DEAD_R;
          cnt_load = !dt_zero;
        end
        ST_MAIN_ON: if (!i_oc1ref) begin
          state_d  = dt_zero ? ST_COMP_ON : ST_DEAD_F;
          cnt_load = !dt_zero;
        end
        ST_DEAD_R: if (!i_oc1ref) begin
          state_d  = dt_zero ? ST_COMP_ON : ST_DEAD_F;
          cnt_load = !dt_zero;
        end else if (cnt_zero) begin
          state_d = ST_MAIN_ON;
        end else begin
          cnt_dec = 1'b1;
        end
        ST_DEAD_F: if (i_oc1ref) begin
          state_d  = dt_zero ? ST_MAIN_ON : ST_DEAD_R;
          cnt_load = !dt_zero;
        end else if (cnt_zero) begin
          state_d = ST_COMP_ON;
        end else begin
          cnt_dec = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    oc1_d  = i_cc1P ^ (i_cc1E & (state_d == ST_MAIN_ON));
    oc1n_d = i_cc1NP ^ (i_cc1NE & (state_d == ST_COMP_ON));
    busy_d = (state_d == ST_DEAD_R) | (state_d == ST_DEAD_F);
    if (!i_moe) begin
      oc1_d  = i_ois1;
      oc1n_d = i_ois1n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cc1e_q  <= 1'b0;
      cc1ne_q <= 1'b0;
      oc1_q   <= 1'b0;
      oc1n_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cc1e_q  <= i_cc1E;
      cc1ne_q <= i_cc1NE;
      oc1_q   <= oc1_d;
      oc1n_q  <= oc1n_d;
      busy_q  <= busy_d;
    end
  end

  assign o_oc1       = oc1_q;
  assign o_oc1n      = oc1n_q;
  assign o_dt_busy   = busy_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_tim1_dtg.sv
// Bench for tim1_dtg: a run-length reference model predicts each edge's outputs
// into a queue; a monitor pops and compares one entry per clock edge.
module tb_tim1_dtg;
  import tim1_pkg::*;

  localparam int DT_W  = 8;
  localparam int EXP_W = 9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            oc1ref = 1'b0;
  logic            cc1e = 1'b0, cc1p = 1'b0, cc1ne = 1'b0, cc1np = 1'b0;
  logic            moe = 1'b0, ois1 = 1'b0, ois1n = 1'b0;
  logic [DT_W-1:0] dtg = '0;
  logic            o_oc1, o_oc1n, o_dt_busy;
  logic [2:0]      o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // {excl_chk, p, np, state[2:0], busy, oc1n, oc1}
  logic [EXP_W-1:0] exp_q[$];

  // Reference model state: length of the current ref run and the dead time latched at its start.
  logic m_fresh = 1'b1;
  logic m_run_ok = 1'b1;
  int   m_run_len = 0;
  int   m_run_dt = 0;
  logic m_prev_ref = 1'b0, m_prev_e = 1'b0, m_prev_ne = 1'b0;

  tim1_dtg #(.DT_W(DT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_oc1ref    (oc1ref),
    .i_cc1E      (cc1e),
    .i_cc1P      (cc1p),
    .i_cc1NE     (cc1ne),
    .i_cc1NP     (cc1np),
    .i_moe       (moe),
    .i_ois1      (ois1),
    .i_ois1n     (ois1n),
    .i_dtg       (dtg),
    .o_oc1       (o_oc1),
    .o_oc1n      (o_oc1n),
    .o_dt_busy   (o_dt_busy),
    .o_dbg_state (o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp_v);
    end
  endtask

  // Drive ref for one full cycle; all stimulus changes land on the falling edge.
  task automatic tick(input logic r);
    oc1ref = r;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    logic       comp, dead, m_act, c_act;
    logic [2:0] st;
    if (!rst_n) begin
      m_fresh = 1'b1;
      st = ST_IDLE;
      exp_q.push_back({3'b000, st, 3'b000});
    end else if (!moe) begin
      m_fresh = 1'b1;
      st = ST_IDLE;
      exp_q.push_back({3'b000, st, 1'b0, ois1n, ois1});
    end else begin
      comp = cc1e & cc1ne;
      if (m_fresh || !comp || (cc1e != m_prev_e) || (cc1ne != m_prev_ne)) begin
        m_run_ok = 1'b1;
      end else if (oc1ref != m_prev_ref) begin
        m_run_ok  = 1'b0;
        m_run_len = 1;
        m_run_dt  = int'(dtg);
      end else if (m_run_len < 100000) begin
        m_run_len++;
      end
      dead  = !m_run_ok && (m_run_len <= m_run_dt);
      m_act = oc1ref && !dead;
      c_act = !oc1ref && !dead;
      if (dead) st = oc1ref ? ST_DEAD_R : ST_DEAD_F;
      else      st = oc1ref ? ST_MAIN_ON : ST_COMP_ON;
      exp_q.push_back({comp, cc1p, cc1np, st, dead, cc1np ^ (cc1ne & c_act), cc1p ^ (cc1e & m_act)});
      m_fresh = 1'b0;
    end
    m_prev_ref = oc1ref;
    m_prev_e   = rst_n ? cc1e : 1'b0;
    m_prev_ne  = rst_n ? cc1ne : 1'b0;
  end

  always @(posedge clk) begin
    logic [EXP_W-1:0] e;
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_empty t=%0t actual=0 entries expected=1", $time);
    end else begin
      e = exp_q.pop_front();
      chk("oc1", {2'b00, o_oc1}, {2'b00, e[0]});
      chk("oc1n", {2'b00, o_oc1n}, {2'b00, e[1]});
      chk("dt_busy", {2'b00, o_dt_busy}, {2'b00, e[2]});
      chk("state", o_dbg_state, e[5:3]);
      if (e[8]) chk("exclusive", {2'b00, (o_oc1 ^ e[7]) & (o_oc1n ^ e[6])}, 3'b000);
    end
  end

  initial begin
    logic r;
    repeat (3) @(negedge clk);
    chk("reset_oc1", {2'b00, o_oc1}, 3'd0);
    chk("reset_oc1n", {2'b00, o_oc1n}, 3'd0);
    chk("reset_busy", {2'b00, o_dt_busy}, 3'd0);
    rst_n = 1'b1;

    // Complementary, dtg=4: long high run then long low run.
    cc1e = 1'b1; cc1ne = 1'b1; moe = 1'b1; dtg = 8'd4;
    repeat (6) tick(1'b0);
    repeat (10) tick(1'b1);
    repeat (8) tick(1'b0);

    // Pulse shorter than the dead time is swallowed.
    dtg = 8'd5;
    repeat (3) tick(1'b1);
    repeat (8) tick(1'b0);

    // Zero dead time with ref toggling every cycle.
    dtg = 8'd0;
    for (int i = 0; i < 12; i++) tick(i[0]);

    // Single main output, inverted polarities.
    cc1p = 1'b1; cc1np = 1'b1; cc1ne = 1'b0; dtg = 8'd3;
    repeat (3) tick(1'b0);
    repeat (2) tick(1'b1);
    repeat (4) tick(1'b0);

    // Main output enable dropped during a rising dead interval.
    cc1p = 1'b0; cc1np = 1'b0; cc1ne = 1'b1; dtg = 8'd6;
    repeat (4) tick(1'b0);
    repeat (2) tick(1'b1);
    moe = 1'b0; ois1 = 1'b1; ois1n = 1'b0;
    repeat (2) tick(1'b1);
    moe = 1'b1;
    repeat (3) tick(1'b1);
    repeat (8) tick(1'b0);

    // Dead-time value changed mid-interval.
    dtg = 8'd6;
    tick(1'b1);
    dtg = 8'd2;
    repeat (9) tick(1'b1);
    repeat (8) tick(1'b0);

    // Enable change aborts a dead interval.
    dtg = 8'd7;
    repeat (2) tick(1'b1);
    cc1ne = 1'b0;
    repeat (3) tick(1'b1);
    cc1ne = 1'b1;
    repeat (4) tick(1'b0);
    cc1e = 1'b0;
    repeat (3) tick(1'b0);
    cc1e = 1'b1;
    repeat (10) tick(1'b0);

    // Reset pulse in the middle of a dtg=8 dead interval.
    dtg = 8'd8;
    repeat (4) tick(1'b0);
    repeat (3) tick(1'b1);
    rst_n = 1'b0;
    oc1ref = 1'b0;
    #1;
    chk("midreset_oc1", {2'b00, o_oc1}, 3'd0);
    chk("midreset_oc1n", {2'b00, o_oc1n}, 3'd0);
    chk("midreset_busy", {2'b00, o_dt_busy}, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) tick(1'b0);

    // Randomised run lengths, dead times, modes, polarities, idle and resets.
    r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3, 0) == 0) r = ~r;
      if ($urandom_range(15, 0) == 0) dtg = 8'($urandom_range(7, 0));
      if ($urandom_range(63, 0) == 0) begin
        cc1e  = ($urandom_range(3, 0) != 0);
        cc1ne = ($urandom_range(3, 0) != 0);
      end
      if ($urandom_range(63, 0) == 0) begin
        cc1p  = 1'($urandom_range(1, 0));
        cc1np = 1'($urandom_range(1, 0));
      end
      moe   = ($urandom_range(39, 0) != 0);
      ois1  = 1'($urandom_range(1, 0));
      ois1n = 1'($urandom_range(1, 0));
      rst_n = ($urandom_range(499, 0) != 0);
      tick(r);
    end
    rst_n = 1'b1;
    moe = 1'b1;
    repeat (3) tick(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tim1_dtg.md
TIM1_DTG -- requirements
Module: tim1_dtg

Interface
REQ-001 Parameter DT_W, default 8: width of the dead-time count in clk cycles.
REQ-002 clk  in  1  single timer kernel clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_oc1ref  in  1  channel-1 reference waveform from the compare stage, synchronous to clk.
REQ-005 i_cc1E / i_cc1P / i_cc1NE / i_cc1NP  in  1 each  enable and polarity bits from the capture/compare enable register (CC1 main and complementary).
REQ-006 i_moe  in  1  main output enable; 0 forces idle levels.
REQ-007 i_ois1 / i_ois1n  in  1 each  idle output levels applied while i_moe=0.
REQ-008 i_dtg  in  DT_W  dead-time length in clk cycles.
REQ-009 o_oc1 / o_oc1n  out  1 each  registered pin-level main and complementary outputs.
REQ-010 o_dt_busy  out  1  high while a dead-time interval is running.

Function
REQ-011 FSM states SHALL be IDLE, COMP_ON, DEAD_R, MAIN_ON, DEAD_F; all outputs SHALL be registered.
REQ-012 i_moe=0 SHALL force o_oc1=i_ois1, o_oc1n=i_ois1n and state IDLE on the next edge, regardless of other inputs.
REQ-013 With i_moe=1, leaving IDLE SHALL go to MAIN_ON if i_oc1ref=1 and to COMP_ON if 0, without dead time.
REQ-014 Complementary mode (cc1E=1, cc1NE=1): a ref rise sampled at edge N SHALL deassert OC1N after edge N; it SHALL enter DEAD_R and assert OC1 after edge N+i_dtg.
REQ-015 Symmetric: a ref fall sampled at edge N SHALL deassert OC1 after edge N; it SHALL enter DEAD_F and assert OC1N after edge N+i_dtg.
REQ-016 i_dtg=0 SHALL transition directly between COMP_ON and MAIN_ON with no dead state and o_dt_busy never high.
REQ-017 If ref reverses during DEAD_R (or DEAD_F), the FSM SHALL enter the opposite dead state with the counter reloaded; the pending output SHALL never assert (pulses shorter than the dead time are swallowed).
REQ-018 i_dtg SHALL be latched at the start of each dead interval; changes mid-interval SHALL have no effect until the next reload.
REQ-019 Single mode (exactly one of cc1E/cc1NE = 1): the enabled output SHALL follow ref (OC1=ref, OC1N=~ref) with 1-cycle latency and no dead time; the disabled output SHALL be inactive.
REQ-020 Neither enable set: both outputs SHALL be inactive and o_dt_busy=0.
REQ-021 Active level SHALL be 1 XOR polarity bit; the inactive level SHALL equal the polarity bit (cc1P for OC1, cc1NP for OC1N).
REQ-022 A change of cc1E or cc1NE SHALL abort any dead interval and resynchronise the FSM to MAIN_ON/COMP_ON per current ref on the next edge.
REQ-023 o_dt_busy SHALL be 1 exactly while state is DEAD_R or DEAD_F.
REQ-024 OC1 and OC1N SHALL never be simultaneously active (pre-polarity) in complementary mode.

Reset
REQ-025 rst_n low SHALL asynchronously set state IDLE, counter 0, o_oc1=0, o_oc1n=0, o_dt_busy=0.
REQ-026 After rst_n deasserts, the first edge with i_moe=1 SHALL follow REQ-013.
REQ-027 Reset asserted mid dead-time SHALL discard the interval; no delayed edge SHALL appear after release.

Structure
REQ-028 Package tim1_pkg SHALL hold the FSM state encoding and the DT_W default constant.
REQ-029 One sub-module, tim1_dt_cnt (loadable DT_W-bit down-counter with zero flag), SHALL implement the dead-time count.

Verification
REQ-030 Complementary, P=NP=0, dtg=4, ref 0->1 at edge 10 -> OC1N=0 after edge 10, OC1=1 after edge 14, o_dt_busy high after edges 10-13.
REQ-031 dtg=5, ref high for 3 cycles -> OC1 stays 0 throughout; OC1N returns 1 exactly 5 cycles after the ref fall.
REQ-032 dtg=0, ref toggling every cycle -> outputs are exact complements, 1-cycle latency, o_dt_busy never 1.
REQ-033 P=1, NP=1, cc1NE=0, ref pulse -> OC1=~ref delayed 1 cycle, OC1N constant 1.
REQ-034 moe 1->0 with ois1=1, ois1n=0 during DEAD_R -> next edge OC1=1, OC1N=0, state IDLE, busy=0.
REQ-035 rst_n pulse low mid dead-time (dtg=8) -> outputs 0 immediately; no OC1 assertion after release until a new ref edge.
